// File: rtl/fpu_divider.sv
// Multi-cycle IEEE-754 single-precision divider: radix-2 restoring mantissa division, RNE rounding.
// Optional sticky status output enabled by defining FPU_DIV_FLAGS_EN.
//
// state  | meaning
// IDLE   | no operation in progress; start accepted here
// DIV    | 27 quotient-bit cycles, counter 26..0
// NORM   | normalise/round (or select special result), register out, pulse done
module fpu_divider #(
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] number1,
  input  logic [31:0] number2,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
`ifdef FPU_DIV_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        div_q, div_d;
  logic [24:0]        rem_q, rem_d;
  logic [26:0]        quo_q, quo_d;
  logic               special_q, special_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic [31:0]        out_q, out_d;
  logic               done_q, done_d;

  logic [7:0]  e1, e2;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic        spec_hit;
  logic [31:0] spec_res;

  assign e1     = number1[30:23];
  assign e2     = number2[30:23];
  assign a_zero = (e1 == 8'h00);
  assign b_zero = (e2 == 8'h00);
  assign a_inf  = (e1 == 8'hFF) && (number1[22:0] == 23'd0);
  assign b_inf  = (e2 == 8'hFF) && (number2[22:0] == 23'd0);
  assign a_nan  = (e1 == 8'hFF) && (number1[22:0] != 23'd0);
  assign b_nan  = (e2 == 8'hFF) && (number2[22:0] != 23'd0);

  // Priority matters: invalid first, then the infinity cases, then the zero cases.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = NAN_CANON;
    end else if (a_inf || b_zero) begin
      spec_res = {number1[31] ^ number2[31], 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      spec_res = {number1[31] ^ number2[31], 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

`ifdef FPU_DIV_FLAGS_EN
  logic [3:0] spec_flg;
  logic [3:0] spec_flg_q, spec_flg_d;
  logic [3:0] flags_q, flags_d;

  always_comb begin
    spec_flg = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_flg = 4'b1000;
    else if (b_zero && !a_inf)
      spec_flg = 4'b0100;
  end
`endif

  logic [24:0]       rem_sub;
  logic              rem_ge;
  logic [22:0]       mant_n;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_n, exp_r;
  logic              norm_of, norm_uf;
  logic [31:0]       norm_res;

  assign rem_ge  = (rem_q >= {1'b0, div_q});
  assign rem_sub = rem_q - {1'b0, div_q};

  always_comb begin
    if (quo_q[26]) begin
      mant_n = quo_q[25:3];
      guard  = quo_q[2];
      sticky = (|quo_q[1:0]) | (|rem_q);
      exp_n  = exp_q;
    end else begin
      mant_n = quo_q[24:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
      exp_n  = exp_q - 10'sd1;
    end
    round_up = guard & (mant_n[0] | sticky);
    mant_r   = {1'b0, mant_n} + {23'd0, round_up};
    // A carry out leaves mant_r[22:0] at zero, which is the correct mantissa.
    exp_r    = exp_n + $signed({9'd0, mant_r[23]});
    norm_of  = (exp_r >= 10'sd255);
    norm_uf  = (exp_r <= 10'sd0);
    if (norm_of)
      norm_res = {sign_q, 8'hFF, 23'd0};
    else if (norm_uf)
      norm_res = {sign_q, 31'd0};
    else
      norm_res = {sign_q, exp_r[7:0], mant_r[22:0]};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    div_d      = div_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    out_d      = out_q;
    done_d     = 1'b0;
`ifdef FPU_DIV_FLAGS_EN
    spec_flg_d = spec_flg_q;
    flags_d    = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d     = number1[31] ^ number2[31];
          exp_d      = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
          div_d      = {1'b1, number2[22:0]};
          rem_d      = {2'b01, number1[22:0]};
          quo_d      = 27'd0;
          cnt_d      = 5'd26;
          special_d  = spec_hit;
          spec_res_d = spec_res;
`ifdef FPU_DIV_FLAGS_EN
          spec_flg_d = spec_flg;
`endif
          state_d    = spec_hit ? S_NORM : S_DIV;
        end
      end
      S_DIV: begin
        if (rem_ge) begin
          quo_d = {quo_q[25:0], 1'b1};
          rem_d = rem_sub << 1;
        end else begin
          quo_d = {quo_q[25:0], 1'b0};
          rem_d = rem_q << 1;
        end
        if (cnt_q == 5'd0)
          state_d = S_NORM;
        else
          cnt_d = cnt_q - 5'd1;
      end
      S_NORM: begin
        out_d   = special_q ? spec_res_q : norm_res;
`ifdef FPU_DIV_FLAGS_EN
        flags_d = special_q ? spec_flg_q : {2'b00, norm_of, norm_uf};
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      sign_q     <= 1'b0;
      exp_q      <= 10'sd0;
      div_q      <= 24'd0;
      rem_q      <= 25'd0;
      quo_q      <= 27'd0;
      special_q  <= 1'b0;
      spec_res_q <= 32'd0;
      out_q      <= 32'd0;
      done_q     <= 1'b0;
`ifdef FPU_DIV_FLAGS_EN
      spec_flg_q <= 4'd0;
      flags_q    <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      out_q      <= out_d;
      done_q     <= done_d;
`ifdef FPU_DIV_FLAGS_EN
      spec_flg_q <= spec_flg_d;
      flags_q    <= flags_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign out  = out_q;
`ifdef FPU_DIV_FLAGS_EN
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fpu_divider.sv
// Scoreboard bench for fpu_divider: directed cases plus randomized operands against an arithmetic model.
module tb_fpu_divider;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] number1, number2;
  logic        busy, done;
  logic [31:0] out;
`ifdef FPU_DIV_FLAGS_EN
  logic [3:0]  flags;
`endif

  fpu_divider dut (
    .clock(clock), .reset(reset), .start(start),
    .number1(number1), .number2(number2),
    .busy(busy), .done(done), .out(out)
`ifdef FPU_DIV_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Returns {special, flags[3:0], result[31:0]} computed with plain integer arithmetic.
  function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    longint unsigned na, nb, q, r, mant;
    bit an, ai, az, bn, bi, bz, g, st;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 4'b1000, 32'h7FC00000};
    if (ai || bz) return {1'b1, (bz && !ai) ? 4'b0100 : 4'b0000, s, 8'hFF, 23'h0};
    if (az || bi) return {1'b1, 4'b0000, s, 31'h0};
    na = 64'(a[22:0]) | 64'h800000;
    nb = 64'(b[22:0]) | 64'h800000;
    q  = (na << 26) / nb;
    r  = (na << 26) % nb;
    e  = ea - eb + 127;
    if (q >= (64'd1 << 26)) begin
      mant = (q >> 3) & 64'h7FFFFF;
      g    = q[2];
      st   = (q[1:0] != 0) || (r != 0);
    end else begin
      e    = e - 1;
      mant = (q >> 2) & 64'h7FFFFF;
      g    = q[1];
      st   = q[0] || (r != 0);
    end
    if (g && (mant[0] || st)) mant = mant + 1;
    if (mant == 64'h800000) begin
      mant = 0;
      e    = e + 1;
    end
    if (e >= 255) return {1'b0, 4'b0010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {1'b0, 4'b0001, s, 31'h0};
    return {1'b0, 4'b0000, s, 8'(e), 23'(mant)};
  endfunction

  // Monitor: pops one expectation per done pulse; reports missing or unexpected dones.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", out, mon_e.res);
        chk("done_cycle", cyc, mon_e.cyc);
`ifdef FPU_DIV_FLAGS_EN
        chk("flags", {28'd0, flags}, {28'd0, mon_e.flg});
`endif
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      mon_e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_done actual=none required=cycle%0d res=%h", mon_e.cyc, mon_e.res);
    end
  end

  // Called at a negedge; the start is sampled at the next posedge (cycle 0 = current cycle).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                       input bit use_model, input logic [31:0] res_c, input logic [3:0] flg_c,
                       output int dcyc);
    logic [36:0] r;
    exp_t e;
    r = ref_div(a, b);
    number1 = a;
    number2 = b;
    start   = 1'b1;
    dcyc    = cyc + (r[36] ? 2 : 29);
    if (push) begin
      e.res = use_model ? r[31:0] : res_c;
      e.flg = use_model ? r[35:32] : flg_c;
      e.cyc = dcyc;
      sb.push_back(e);
    end
    @(negedge clock);
    start   = 1'b0;
    number1 = $urandom;
    number2 = $urandom;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] ex;
    logic [22:0] m;
    case ($urandom_range(0, 11))
      0: ex = 8'h00;
      1: ex = 8'hFF;
      2: ex = 8'h01;
      3: ex = 8'hFE;
      default: ex = 8'($urandom_range(64, 190));
    endcase
    m = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), ex, m};
  endfunction

  int n0, d, d2;

  initial begin
    reset = 1'b1; start = 1'b0; number1 = 32'd0; number2 = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_out", out, 32'd0);
`ifdef FPU_DIV_FLAGS_EN
    chk("reset_flags", {28'd0, flags}, 32'd0);
`endif
    @(negedge clock);

    // 6.0 / 2.0 with cycle-exact busy profile
    n0 = cyc;
    issue(32'h40C00000, 32'h40000000, 1'b1, 1'b0, 32'h40400000, 4'b0000, d);
    for (int k = 1; k <= 29; k++) begin
      chk($sformatf("busy_c%0d", k), {31'd0, busy}, (k <= 28) ? 32'd1 : 32'd0);
      @(negedge clock);
    end

    issue(32'h3F800000, 32'h40400000, 1'b1, 1'b0, 32'h3EAAAAAB, 4'b0000, d);
    wait_until(d);
    issue(32'h40400000, 32'h40400000, 1'b1, 1'b0, 32'h3F800000, 4'b0000, d);
    wait_until(d);

    // Special operands: two-cycle latency
    issue(32'hBF800000, 32'h00000000, 1'b1, 1'b0, 32'hFF800000, 4'b0100, d);
    chk("special_busy_c1", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("special_busy_c2", {31'd0, busy}, 32'd0);
    issue(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h7FC00000, 4'b1000, d);
    wait_until(d);
    issue(32'h7F000000, 32'h00800000, 1'b1, 1'b0, 32'h7F800000, 4'b0010, d);
    wait_until(d);
    issue(32'h00800000, 32'h7F000000, 1'b1, 1'b0, 32'h00000000, 4'b0001, d);
    wait_until(d + 1);

    // Starts while busy are ignored; start in the done cycle is accepted
    n0 = cyc;
    issue(32'h3F800000, 32'h40400000, 1'b1, 1'b0, 32'h3EAAAAAB, 4'b0000, d);
    wait_until(n0 + 5);
    start = 1'b1; number1 = 32'h40C00000; number2 = 32'h3F800000;
    @(negedge clock);
    start = 1'b0;
    wait_until(n0 + 20);
    start = 1'b1; number1 = 32'h00000000; number2 = 32'h00000000;
    @(negedge clock);
    start = 1'b0;
    wait_until(d);
    issue(32'h40C00000, 32'h40000000, 1'b1, 1'b0, 32'h40400000, 4'b0000, d2);
    wait_until(d2 + 2);

    // Reset mid-operation aborts with no done
    n0 = cyc;
    issue(32'h41200000, 32'h40400000, 1'b0, 1'b0, 32'h0, 4'b0000, d);
    wait_until(n0 + 10);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", out, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (35) @(negedge clock);
    issue(32'h41200000, 32'h40000000, 1'b1, 1'b0, 32'h40A00000, 4'b0000, d);
    wait_until(d);

    // Randomized operands, mostly back-to-back
    for (int i = 0; i < 200; i++) begin
      issue(rnd_fp(), rnd_fp(), 1'b1, 1'b1, 32'h0, 4'b0000, d);
      if ($urandom_range(0, 3) == 0)
        wait_until(d + $urandom_range(1, 3));
      else
        wait_until(d);
    end

    repeat (40) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_divider.md
Name: fpu_divider

Overview:
- Multi-cycle IEEE-754 single-precision divider (out = number1 / number2); companion to the combinational FP adder in the FPU.
- Radix-2 restoring mantissa division, one quotient bit per clock; start/busy/done handshake to the execute-stage FPU control.
- Round-to-nearest-even using the adder's rule: round up = guard && (lsb || sticky).

Parameters:
- NAN_CANON, 32'h7FC00000, result word for invalid operations.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  accept operands; honoured only when busy=0
- number1  input  32  dividend, IEEE-754 single
- number2  input  32  divisor, IEEE-754 single
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; out valid from this cycle
- out  output  32  quotient, held until the next accepted start

Behaviour:
- Reset: one clock, synchronous, active-high. On the reset edge: state=IDLE, busy=0, done=0, out=0, counter=0. Reset mid-operation aborts the operation; no done is issued.
- States:
  - IDLE: no operation in progress.
  - DIV: 27 cycles; down-counter 26..0.
  - NORM: 1 cycle.
- IDLE, start=1 at an edge:
  - Register the signs, exponents and {1,mantissa} of both operands.
  - Sign = s1^s2.
  - Biased exponent = e1 - e2 + 127, 10-bit signed.
  - Next state is DIV, or NORM directly when the special flag is set.
- Special classification, evaluated at capture:
  - Exponent 0 means zero; denormal inputs flush to zero.
  - NaN operand, 0/0 or inf/inf gives NAN_CANON.
  - inf/x or x/0 gives {sign,8'hFF,23'b0}.
  - 0/x or x/inf gives {sign,31'b0}.
- DIV, each cycle:
  - If rem >= divisor: shift in q=1 and rem = (rem - divisor) << 1.
  - Otherwise: shift in q=0 and rem = rem << 1.
  - Initial rem = dividend mantissa, 25 bits.
  - Leave DIV when the counter reaches 0.
- NORM, quotient q[26:0]:
  - q[26]=1: mantissa = q[25:3], guard = q[2], sticky = |q[1:0] | (rem!=0).
  - q[26]=0: mantissa = q[24:2], guard = q[1], sticky = q[0] | (rem!=0); exponent -1.
  - Rounding carry out of the mantissa increments the exponent; the mantissa becomes 0.
  - Exponent >= 255 after rounding gives ±inf. Exponent <= 0 gives ±0 (flush, no denormal output).
  - Register out, pulse done, return to IDLE.
- Latency, with start sampled in cycle 0:
  - Normal operands: busy high in cycles 1..28, done high in cycle 29 only.
  - Special operands: busy high in cycle 1, done high in cycle 2.
- Handshake:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start in the done cycle is accepted, giving back-to-back operation.
  - Operands may change freely after the capture edge.
- out changes only in the NORM-exit edge and on reset.

Optional Feature:
- Macro: FPU_DIV_FLAGS_EN
- When defined:
  - Adds output flags [3:0] = {NV, DZ, OF, UF}, registered alongside out in the same edge.
  - NV: invalid (NAN_CANON result). DZ: finite nonzero / 0. OF: exponent overflow to inf. UF: nonzero result flushed to 0.
  - flags reset to 0 and hold until the next result.
- When undefined: the flags port and its logic are absent; all other behaviour is identical.

Test Plan:
- 32'h40C00000 / 32'h40000000 (6.0/2.0), start in cycle 0 -> busy cycles 1..28, done in cycle 29 only, out=32'h40400000.
- 32'h3F800000 / 32'h40400000 (1/3) -> out=32'h3EAAAAAB (round-up path); then 32'h40400000 / 32'h40400000 -> 32'h3F800000 (q[26]=1 path).
- 32'hBF800000 / 32'h00000000 -> done in cycle 2, out=32'hFF800000, flags=4'b0100 with FPU_DIV_FLAGS_EN; then 0/0 -> 32'h7FC00000, flags=4'b1000.
- 32'h7F000000 / 32'h00800000 -> out=32'h7F800000 (OF); 32'h00800000 / 32'h7F000000 -> out=32'h00000000 (UF).
- Second start pulses in cycles 5 and 20 with different operands -> ignored; first result is unchanged. New start in the done cycle (29) -> done in cycle 58.
- reset asserted in cycle 10 of an operation -> busy=0, out=0 next cycle, no done pulse; a following start completes normally.
